ndp_axis_operand_loader: RTL and testbench

NDP_AXIS_OPERAND_LOADER -- requirements
Module: ndp_axis_operand_loader

---
 rtl/ndp_axis_operand_loader.sv | 167 ++++++++++++++++
 tb/tb_ndp_axis_operand_loader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ndp_axis_operand_loader.sv
// Streams A-column and B-row operand segments from an AXI-Stream source and presents one
// (a_vec, b_vec) pair per reduction step k, with tlast framing checked against the job length.
`timescale 1ns/1ps

module ndp_axis_operand_loader #(
    parameter int unsigned AXIS_WIDTH = 32,
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned A_ROWS     = 4,
    parameter int unsigned B_COLS     = 64,
    parameter int unsigned K_MAX      = 64,
    localparam int unsigned KW        = $clog2(K_MAX + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [KW-1:0]              cfg_k,
    input  logic [AXIS_WIDTH-1:0]      s_axis_tdata,
    input  logic                       s_axis_tvalid,
    input  logic                       s_axis_tlast,
    output logic                       s_axis_tready,
    output logic [A_ROWS*WIDTH-1:0]    a_vec,
    output logic [B_COLS*WIDTH-1:0]    b_vec,
    output logic                       vec_valid,
    input  logic                       vec_ready,
    output logic                       vec_last,
    output logic                       busy,
    output logic                       done,
    output logic                       err_tlast,
    output logic                       err_cfg
);

    localparam int unsigned NumWordsA = A_ROWS * WIDTH / AXIS_WIDTH;
    localparam int unsigned NumWordsB = B_COLS * WIDTH / AXIS_WIDTH;
    localparam int unsigned NumWordsMax = (NumWordsA > NumWordsB) ? NumWordsA : NumWordsB;
    localparam int unsigned CW = (NumWordsMax > 1) ? $clog2(NumWordsMax) : 1;
    localparam logic [CW-1:0] WordALast = CW'(NumWordsA - 1);
    localparam logic [CW-1:0] WordBLast = CW'(NumWordsB - 1);

    typedef enum logic [1:0] {StIdle, StLoadA, StLoadB, StEmit} state_e;

    state_e                    state_q, state_d;
    logic [KW-1:0]             k_q, k_d;
    logic [KW-1:0]             kcfg_q, kcfg_d;
    logic [CW-1:0]             wcnt_q, wcnt_d;
    logic [A_ROWS*WIDTH-1:0]   a_vec_q, a_vec_d;
    logic [B_COLS*WIDTH-1:0]   b_vec_q, b_vec_d;
    logic                      err_tlast_q, err_tlast_d;
    logic                      early_q, early_d;
    logic                      done_q, done_d;
    logic                      err_cfg_q, err_cfg_d;

    logic word_hs;
    logic cfg_ok;
    logic final_step;
    logic tlast_exp;
    logic step_last;

    assign word_hs    = s_axis_tvalid && s_axis_tready;
    assign cfg_ok     = (cfg_k != '0) && (cfg_k <= KW'(K_MAX));
    assign final_step = (k_q == kcfg_q - KW'(1));
    assign tlast_exp  = final_step && (wcnt_q == WordBLast);
    // An early tlast truncates the job: the vector in flight becomes the last one.
    assign step_last  = final_step || early_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            k_q         <= '0;
            kcfg_q      <= '0;
            wcnt_q      <= '0;
            a_vec_q     <= '0;
            b_vec_q     <= '0;
            err_tlast_q <= 1'b0;
            early_q     <= 1'b0;
            done_q      <= 1'b0;
            err_cfg_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            kcfg_q      <= kcfg_d;
            wcnt_q      <= wcnt_d;
            a_vec_q     <= a_vec_d;
            b_vec_q     <= b_vec_d;
            err_tlast_q <= err_tlast_d;
            early_q     <= early_d;
            done_q      <= done_d;
            err_cfg_q   <= err_cfg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start && cfg_ok) state_d = StLoadA;
            StLoadA: if (word_hs && (wcnt_q == WordALast)) state_d = StLoadB;
            StLoadB: if (word_hs && (wcnt_q == WordBLast)) state_d = StEmit;
            StEmit:  if (vec_ready) state_d = step_last ? StIdle : StLoadA;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        k_d         = k_q;
        kcfg_d      = kcfg_q;
        wcnt_d      = wcnt_q;
        a_vec_d     = a_vec_q;
        b_vec_d     = b_vec_q;
        err_tlast_d = err_tlast_q;
        early_d     = early_q;
        done_d      = 1'b0;
        err_cfg_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (cfg_ok) begin
                        kcfg_d      = cfg_k;
                        k_d         = '0;
                        wcnt_d      = '0;
                        err_tlast_d = 1'b0;
                        early_d     = 1'b0;
                    end else begin
                        err_cfg_d = 1'b1;
                    end
                end
            end
            StLoadA: begin
                if (word_hs) begin
                    a_vec_d[32'(wcnt_q) * AXIS_WIDTH +: AXIS_WIDTH] = s_axis_tdata;
                    wcnt_d = (wcnt_q == WordALast) ? '0 : wcnt_q + CW'(1);
                    if (s_axis_tlast) begin
                        err_tlast_d = 1'b1;
                        early_d     = 1'b1;
                    end
                end
            end
            StLoadB: begin
                if (word_hs) begin
                    b_vec_d[32'(wcnt_q) * AXIS_WIDTH +: AXIS_WIDTH] = s_axis_tdata;
                    wcnt_d = (wcnt_q == WordBLast) ? '0 : wcnt_q + CW'(1);
                    if (s_axis_tlast != tlast_exp) err_tlast_d = 1'b1;
                    if (s_axis_tlast && !tlast_exp) early_d = 1'b1;
                end
            end
            StEmit: begin
                if (vec_ready) begin
                    if (step_last) done_d = 1'b1;
                    else           k_d    = k_q + KW'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        s_axis_tready = (state_q == StLoadA) || (state_q == StLoadB);
        vec_valid     = (state_q == StEmit);
        vec_last      = (state_q == StEmit) && step_last;
        busy          = (state_q != StIdle);
    end

    assign a_vec     = a_vec_q;
    assign b_vec     = b_vec_q;
    assign done      = done_q;
    assign err_tlast = err_tlast_q;
    assign err_cfg   = err_cfg_q;

endmodule

// File: tb/tb_ndp_axis_operand_loader.sv
// Directed bench for ndp_axis_operand_loader: default build plus a 64-bit-stream build.
`timescale 1ns/1ps

module tb_ndp_axis_operand_loader;

    localparam int unsigned KW = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset, start, vec_ready;
    logic [KW-1:0]   cfg_k;
    logic [31:0]     s_axis_tdata;
    logic            s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic [63:0]     a_vec;
    logic [1023:0]   b_vec;
    logic            vec_valid, vec_last, busy, done, err_tlast, err_cfg;

    logic            w_start, w_vec_ready, w_tvalid, w_tlast, w_tready;
    logic [KW-1:0]   w_cfg_k;
    logic [63:0]     w_tdata, w_a_vec;
    logic [511:0]    w_b_vec;
    logic            w_vec_valid, w_vec_last, w_busy, w_done, w_err_tlast, w_err_cfg;

    int n_checks = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int err_cfg_cnt = 0;

    ndp_axis_operand_loader u_dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .cfg_k         (cfg_k),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .a_vec         (a_vec),
        .b_vec         (b_vec),
        .vec_valid     (vec_valid),
        .vec_ready     (vec_ready),
        .vec_last      (vec_last),
        .busy          (busy),
        .done          (done),
        .err_tlast     (err_tlast),
        .err_cfg       (err_cfg)
    );

    ndp_axis_operand_loader #(
        .AXIS_WIDTH (64),
        .B_COLS     (32)
    ) u_dut_w (
        .clk           (clk),
        .reset         (reset),
        .start         (w_start),
        .cfg_k         (w_cfg_k),
        .s_axis_tdata  (w_tdata),
        .s_axis_tvalid (w_tvalid),
        .s_axis_tlast  (w_tlast),
        .s_axis_tready (w_tready),
        .a_vec         (w_a_vec),
        .b_vec         (w_b_vec),
        .vec_valid     (w_vec_valid),
        .vec_ready     (w_vec_ready),
        .vec_last      (w_vec_last),
        .busy          (w_busy),
        .done          (w_done),
        .err_tlast     (w_err_tlast),
        .err_cfg       (w_err_cfg)
    );

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (err_cfg) err_cfg_cnt <= err_cfg_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stream element j carries the value j, so step k's A starts at element k*(A+B elements).
    function automatic logic [63:0] exp_a(input int base);
        logic [63:0] v;
        for (int e = 0; e < 4; e++) v[e*16 +: 16] = 16'(base + e);
        return v;
    endfunction

    function automatic logic [1023:0] exp_b(input int base, input int ncols);
        logic [1023:0] v;
        v = '0;
        for (int e = 0; e < ncols; e++) v[e*16 +: 16] = 16'(base + 4 + e);
        return v;
    endfunction

    task automatic check_vec(input string tag, input int k, input bit last);
        logic [1023:0] eb;
        eb = exp_b(k * 68, 64);
        check_eq($sformatf("%s.k%0d.a", tag, k), 256'(a_vec), 256'(exp_a(k * 68)));
        for (int c = 0; c < 4; c++)
            check_eq($sformatf("%s.k%0d.b%0d", tag, k, c), b_vec[c*256 +: 256], eb[c*256 +: 256]);
        check_eq($sformatf("%s.k%0d.last", tag, k), 256'(vec_last), 256'(last));
    endtask

    task automatic drive_stream(input int total, input int last_idx, input bit toggle);
        int n;
        int cyc;
        bit hs;
        n = 0;
        cyc = 0;
        while (n < total && cyc < 20000) begin
            @(negedge clk);
            s_axis_tvalid = toggle ? (cyc[0] == 1'b0) : 1'b1;
            s_axis_tdata  = {16'(2 * n + 1), 16'(2 * n)};
            s_axis_tlast  = (n == last_idx);
            hs = s_axis_tvalid && s_axis_tready;
            @(posedge clk);
            if (hs) n++;
            cyc++;
        end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        check_eq("words_sent", 256'(n), 256'(total));
    endtask

    task automatic consume(input string tag, input int nvec, input int hold, input int last_v);
        int t;
        for (int v = 0; v < nvec; v++) begin
            t = 0;
            while (!vec_valid && t < 5000) begin
                @(negedge clk);
                t++;
            end
            if (!vec_valid) begin
                check_eq({tag, ".vec_timeout"}, 256'(0), 256'(1));
                return;
            end
            for (int h = 0; h < hold; h++) begin
                check_eq({tag, ".hold_tready"}, 256'(s_axis_tready), 256'(0));
                check_eq({tag, ".hold_valid"}, 256'(vec_valid), 256'(1));
                @(negedge clk);
            end
            check_vec(tag, v, v == last_v);
            vec_ready = 1'b1;
            @(negedge clk);
            vec_ready = (hold == 0);
        end
    endtask

    task automatic run_job(input string tag, input int kcfg, input int nvec, input int last_idx,
                           input bit toggle, input int hold, input bit exp_err);
        int d0;
        int e0;
        d0 = done_cnt;
        e0 = err_cfg_cnt;
        @(negedge clk);
        cfg_k     = KW'(kcfg);
        start     = 1'b1;
        vec_ready = (hold == 0);
        @(negedge clk);
        start = 1'b0;
        check_eq({tag, ".busy"}, 256'(busy), 256'(1));
        fork
            drive_stream(nvec * 34, last_idx, toggle);
            consume(tag, nvec, hold, nvec - 1);
            begin
                // A bad start mid-job must be ignored, and cfg_k must already be latched.
                repeat (10) @(negedge clk);
                cfg_k = '0;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        check_eq({tag, ".done"}, 256'(done), 256'(1));
        check_eq({tag, ".err_tlast"}, 256'(err_tlast), 256'(exp_err));
        @(negedge clk);
        check_eq({tag, ".done_drop"}, 256'(done), 256'(0));
        check_eq({tag, ".idle"}, 256'(busy), 256'(0));
        check_eq({tag, ".no_extra_vec"}, 256'(vec_valid), 256'(0));
        check_eq({tag, ".err_sticky"}, 256'(err_tlast), 256'(exp_err));
        @(negedge clk);
        check_eq({tag, ".done_count"}, 256'(done_cnt - d0), 256'(1));
        check_eq({tag, ".no_err_cfg"}, 256'(err_cfg_cnt - e0), 256'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int n;
        int nv;
        int cyc;
        bit hs;
        logic [1023:0] eb;

        reset = 1'b1;
        start = 1'b0;
        cfg_k = '0;
        vec_ready = 1'b0;
        s_axis_tdata = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        w_start = 1'b0;
        w_cfg_k = '0;
        w_tdata = '0;
        w_tvalid = 1'b0;
        w_tlast = 1'b0;
        w_vec_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check_eq("rst.busy", 256'(busy), 256'(0));
        check_eq("rst.tready", 256'(s_axis_tready), 256'(0));
        check_eq("rst.vec_valid", 256'(vec_valid), 256'(0));
        check_eq("rst.a_vec", 256'(a_vec), 256'(0));
        check_eq("rst.err", 256'({done, err_tlast, err_cfg, vec_last}), 256'(0));

        run_job("full", 21, 21, 713, 1'b0, 0, 1'b0);
        run_job("stall", 21, 21, 713, 1'b1, 5, 1'b0);
        run_job("early", 3, 2, 40, 1'b0, 0, 1'b1);
        run_job("nolast", 1, 1, -1, 1'b0, 0, 1'b1);

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            cfg_k = (i == 0) ? KW'(0) : KW'(65);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check_eq($sformatf("cfg%0d.err_cfg", i), 256'(err_cfg), 256'(1));
            check_eq($sformatf("cfg%0d.busy", i), 256'(busy), 256'(0));
            check_eq($sformatf("cfg%0d.tready", i), 256'(s_axis_tready), 256'(0));
            @(negedge clk);
            check_eq($sformatf("cfg%0d.pulse", i), 256'(err_cfg), 256'(0));
        end

        // Abandon a job partway into step 2's B segment.
        d0 = done_cnt;
        @(negedge clk);
        cfg_k = KW'(3);
        start = 1'b1;
        vec_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        fork
            drive_stream(75, -1, 1'b0);
            consume("pre_rst", 2, 0, -1);
        join
        check_eq("pre_rst.loading", 256'(s_axis_tready), 256'(1));
        reset = 1'b1;
        start = 1'b1;
        cfg_k = KW'(1);
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        s_axis_tvalid = 1'b0;
        check_eq("mid_rst.flags",
                 256'({s_axis_tready, vec_valid, vec_last, busy, done, err_tlast, err_cfg}),
                 256'(0));
        check_eq("mid_rst.a_vec", 256'(a_vec), 256'(0));
        check_eq("mid_rst.b_vec", 256'(|b_vec), 256'(0));
        repeat (2) @(negedge clk);
        check_eq("mid_rst.no_done", 256'(done_cnt - d0), 256'(0));
        run_job("post_rst", 1, 1, 33, 1'b0, 0, 1'b0);

        // 64-bit stream build: one A word and eight B words per step.
        @(negedge clk);
        w_cfg_k = KW'(4);
        w_start = 1'b1;
        @(negedge clk);
        w_start = 1'b0;
        n = 0;
        nv = 0;
        cyc = 0;
        while (nv < 4 && cyc < 2000) begin
            w_tdata  = {16'(4 * n + 3), 16'(4 * n + 2), 16'(4 * n + 1), 16'(4 * n)};
            w_tvalid = 1'b1;
            w_tlast  = (n == 35);
            if (w_vec_valid) begin
                eb = exp_b(nv * 36, 32);
                check_eq($sformatf("w64.k%0d.a", nv), 256'(w_a_vec), 256'(exp_a(nv * 36)));
                check_eq($sformatf("w64.k%0d.b0", nv), w_b_vec[255:0], eb[255:0]);
                check_eq($sformatf("w64.k%0d.b1", nv), w_b_vec[511:256], eb[511:256]);
                check_eq($sformatf("w64.k%0d.last", nv), 256'(w_vec_last), 256'(nv == 3));
                nv++;
            end
            hs = w_tvalid && w_tready;
            @(posedge clk);
            if (hs) n++;
            @(negedge clk);
            cyc++;
        end
        w_tvalid = 1'b0;
        w_tlast  = 1'b0;
        check_eq("w64.vectors", 256'(nv), 256'(4));
        check_eq("w64.words", 256'(n), 256'(36));
        check_eq("w64.done", 256'(w_done), 256'(1));
        check_eq("w64.err_tlast", 256'(w_err_tlast), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
